// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes X-Y one bit per cycle, LSB first.
// BUSY covers RUN and DONE; DONE is a single-cycle completion pulse.
// D and B hold the last completed result until the next completion or reset.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  // Wide enough to hold WIDTH, so the counter never wraps during RUN.
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             diff;

  // State and datapath registers; everything clears asynchronously on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  // Next-state logic and one full-subtractor bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
    diff    = x_q[0] ^ y_q[0] ^ b_q;

    case (state_q)
      StIdle: begin
        if (START) begin
          x_d     = X;
          y_d     = Y;
          r_d     = '0;
          b_d     = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d           = x_q >> 1;
        y_d           = y_q >> 1;
        r_d           = r_q >> 1;
        r_d[WIDTH-1]  = diff;
        b_d           = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & b_q);
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Publish the completed result on the same edge as the last bit.
          d_d     = r_d;
          bo_d    = b_d;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status and result outputs come straight from registers.
  always_comb begin
    BUSY = (state_q != StIdle);
    DONE = (state_q == StDone);
    D    = d_q;
    B    = bo_q;
  end

endmodule
